// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store and freezes the pipeline
// for LATENCY+1 cycles, then pulses resp_valid with extended load data or an error.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] addr,
  input  logic [63:0] write_data,
  input  logic [2:0]  funct3,
  output logic [63:0] read_data,
  output logic        resp_valid,
  output logic        stall,
  output logic        error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [AW+2:0]   r_addr;
  logic [63:0]     r_wdata;
  logic [2:0]      r_f3;
  logic            r_is_write;
  logic            r_error;
  logic [63:0]     r_read_data;
  logic [63:0]     r_mem [DEPTH];

  logic            w_req;
  logic            w_misalign;
  logic            w_bad;
  logic            w_access;
  logic [AW-1:0]   w_idx;
  logic [7:0]      w_size_mask;
  logic [7:0]      w_lane_mask;
  logic [63:0]     w_wdata_sh;
  logic [63:0]     w_word;
  logic [63:0]     w_rd_sh;
  logic [63:0]     w_load_val;
  logic            w_unused;

  // Address bits above the storage index are deliberately ignored (wrap-around).
  assign w_unused = ^addr[63:AW+3];

  assign w_req = mem_read | mem_write;

  always_comb begin
    w_misalign = 1'b0;
    case (funct3[1:0])
      2'b01:   w_misalign = addr[0];
      2'b10:   w_misalign = |addr[1:0];
      2'b11:   w_misalign = |addr[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_bad    = (funct3 == 3'b111) | (mem_read & mem_write) | w_misalign;
  assign w_access = (r_state == S_BUSY) && (r_cnt == '0);
  assign w_idx    = r_addr[AW+2:3];

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_req;
        if (w_req) w_state_next = w_bad ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        stall = 1'b1;
        if (r_cnt == '0) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign resp_valid = (r_state == S_DONE);
  assign error      = resp_valid & r_error;
  assign read_data  = r_read_data;

  always_comb begin
    w_size_mask = 8'h01;
    case (r_f3[1:0])
      2'b00:   w_size_mask = 8'h01;
      2'b01:   w_size_mask = 8'h03;
      2'b10:   w_size_mask = 8'h0F;
      default: w_size_mask = 8'hFF;
    endcase
  end

  assign w_lane_mask = w_size_mask << r_addr[2:0];
  assign w_wdata_sh  = r_wdata << {r_addr[2:0], 3'b000};
  assign w_word      = r_mem[w_idx];
  assign w_rd_sh     = w_word >> {r_addr[2:0], 3'b000};

  always_comb begin
    w_load_val = 64'd0;
    case (r_f3)
      3'b000:  w_load_val = {{56{w_rd_sh[7]}},  w_rd_sh[7:0]};
      3'b001:  w_load_val = {{48{w_rd_sh[15]}}, w_rd_sh[15:0]};
      3'b010:  w_load_val = {{32{w_rd_sh[31]}}, w_rd_sh[31:0]};
      3'b011:  w_load_val = w_rd_sh;
      3'b100:  w_load_val = {56'd0, w_rd_sh[7:0]};
      3'b101:  w_load_val = {48'd0, w_rd_sh[15:0]};
      3'b110:  w_load_val = {32'd0, w_rd_sh[31:0]};
      default: w_load_val = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_f3        <= '0;
      r_is_write  <= 1'b0;
      r_error     <= 1'b0;
      r_read_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && w_req) begin
        r_addr     <= addr[AW+2:0];
        r_wdata    <= write_data;
        r_f3       <= funct3;
        r_is_write <= mem_write;
        r_cnt      <= LAT_M1;
        r_error    <= w_bad;
        if (w_bad) r_read_data <= '0;
      end else if (r_state == S_BUSY) begin
        if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        else r_read_data <= r_is_write ? 64'd0 : w_load_val;
      end
    end
  end

  // Storage is never reset; a reset at the access edge abandons the store.
  always_ff @(posedge clk) begin
    if (!reset && w_access && r_is_write) begin
      for (int i = 0; i < 8; i++) begin
        if (w_lane_mask[i]) r_mem[w_idx][i*8 +: 8] <= w_wdata_sh[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;
  localparam int NBYTES  = DEPTH * 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] addr;
  logic [63:0] write_data;
  logic [2:0]  funct3;
  logic [63:0] read_data;
  logic        resp_valid;
  logic        stall;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem_b [NBYTES];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .write_data (write_data),
    .funct3     (funct3),
    .read_data  (read_data),
    .resp_valid (resp_valid),
    .stall      (stall),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [2:0] f3);
    int n, base;
    logic [63:0] v;
    n    = 1 << f3[1:0];
    base = int'(a % 64'(NBYTES));
    v    = 64'd0;
    for (int k = 0; k < n; k++) v = v | (64'(mem_b[base + k]) << (8 * k));
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  // Starts and ends at posedge+1 with the DUT idle.
  task automatic do_req(input bit rd, input bit wr, input logic [63:0] a,
                        input logic [63:0] wd, input logic [2:0] f3, input string tag);
    bit          bad;
    int          n, cyc, exp_cyc;
    logic [63:0] exp_rd;
    n       = 1 << f3[1:0];
    bad     = (f3 == 3'b111) || (rd && wr) || ((a % 64'(n)) != 0);
    exp_cyc = bad ? 1 : LATENCY + 1;
    exp_rd  = (!bad && rd) ? model_load(a, f3) : 64'd0;
    mem_read = rd; mem_write = wr; addr = a; write_data = wd; funct3 = f3;
    #1;
    cyc = 0;
    while (stall && cyc < 20) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk({tag, "_stall_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_error"}, 64'(error), 64'(bad));
    chk({tag, "_read_data"}, read_data, exp_rd);
    $display("[TB] %s rd=%0d wr=%0d addr=%h f3=%0d wd=%h -> data=%h err=%0d stall_cyc=%0d",
             tag, rd, wr, a, f3, wd, read_data, error, cyc);
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_rv_clear"}, 64'(resp_valid), 64'd0);
    if (wr && !bad) begin
      int base;
      base = int'(a % 64'(NBYTES));
      for (int k = 0; k < n; k++) mem_b[base + k] = wd[8*k +: 8];
    end
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; write_data = '0; funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_read_data", read_data, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++)
      do_req(1'b0, 1'b1, 64'(i * 8), {$urandom, $urandom}, 3'b011, "fill");

    do_req(1'b0, 1'b1, 64'h10, 64'h1122334455667788, 3'b011, "sd_10");
    do_req(1'b1, 1'b0, 64'h10, 64'h0, 3'b011, "ld_10");
    do_req(1'b0, 1'b1, 64'h21, 64'h80, 3'b000, "sb_21");
    do_req(1'b1, 1'b0, 64'h21, 64'h0, 3'b000, "lb_21");
    do_req(1'b1, 1'b0, 64'h21, 64'h0, 3'b100, "lbu_21");
    do_req(1'b1, 1'b0, 64'h20, 64'h0, 3'b011, "ld_20");
    do_req(1'b1, 1'b0, 64'h06, 64'h0, 3'b010, "lw_mis");
    do_req(1'b1, 1'b0, 64'h00, 64'h0, 3'b011, "ld_0_pre");
    do_req(1'b1, 1'b1, 64'h18, 64'hABCD, 3'b011, "both");
    do_req(1'b0, 1'b1, 64'h18, 64'hABCD, 3'b111, "f3_111");
    do_req(1'b1, 1'b0, 64'h18, 64'h0, 3'b011, "ld_18");
    do_req(1'b0, 1'b1, 64'h200, 64'hCAFEF00D12345678, 3'b011, "sd_wrap");
    do_req(1'b1, 1'b0, 64'h0, 64'h0, 3'b011, "ld_wrap");

    // Reset during BUSY of a store must abandon it.
    mem_write = 1'b1; addr = 64'h8; write_data = 64'hDEAD; funct3 = 3'b011;
    #1;
    chk("rmid_stall_idle", 64'(stall), 64'd1);
    @(posedge clk); #1;
    chk("rmid_stall_busy", 64'(stall), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rmid_resp_valid", 64'(resp_valid), 64'd0);
    chk("rmid_error", 64'(error), 64'd0);
    chk("rmid_stall_req", 64'(stall), 64'd1);
    chk("rmid_read_data", read_data, 64'd0);
    mem_write = 1'b0;
    #1;
    chk("rmid_stall_noreq", 64'(stall), 64'd0);
    $display("[TB] reset mid-store addr=0000000000000008 abandoned");
    reset = 1'b0;
    @(posedge clk); #1;
    do_req(1'b1, 1'b0, 64'h8, 64'h0, 3'b011, "ld_8_after_rst");

    for (int t = 0; t < 300; t++) begin
      bit          rd, wr;
      int          op;
      logic [2:0]  f3;
      logic [63:0] a;
      op = int'($urandom_range(0, 9));
      rd = (op == 0) || (op >= 5);
      wr = (op <= 4);
      f3 = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) a = a % 64'(NBYTES);
      if ($urandom_range(0, 4) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      do_req(rd, wr, a, {$urandom, $urandom}, f3, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
